// File: rtl/ampel_input_stage.sv
// Purpose : pedestrian-button front end and phase-step tick generator for the traffic-light controller.
// Latency : key falling edge -> ped_req high in 2 (sync) + DEBOUNCE_CYCLES + 2 (edge detect, FSM) cycles; tick every TICK_PERIOD cycles.
// Backpressure: ped_req is held until ped_ack; presses while pending are merged, presses during holdoff are dropped.
//
// Ports:
//   CLOCK_50    in   system clock (50 MHz); everything runs in this single domain
//   reset       in   synchronous, active-high reset; overrides all other logic
//   key0, key1  in   raw push buttons, active-low, asynchronous to CLOCK_50
//   ped_ack     in   one-cycle pulse from the light controller accepting the request
//   tick        out  one-cycle phase-step enable (a clock enable, never used as a clock)
//   ped_req     out  pedestrian request level, held until ped_ack
//   key_state   out  debounced key levels, active-high pressed; bit0 = key0, bit1 = key1
//   press_count out  number of accepted requests, wraps 255 -> 0

module ampel_input_stage #(
    parameter int TICK_PERIOD     = 33554432,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLDOFF_TICKS   = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       key0,
    input  logic       key1,
    input  logic       ped_ack,
    output logic       tick,
    output logic       ped_req,
    output logic [1:0] key_state,
    output logic [7:0] press_count
);

    // Counter widths; each is forced to at least one bit so degenerate
    // parameter values still elaborate.
    localparam int TW = (TICK_PERIOD > 1)     ? $clog2(TICK_PERIOD)     : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = (HOLDOFF_TICKS > 0)   ? (($clog2(HOLDOFF_TICKS + 1) > 0) ? $clog2(HOLDOFF_TICKS + 1) : 1) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_PERIOD - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    // Only used when HOLDOFF_TICKS > 0; the zero case is handled separately.
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PENDING = 2'b01,
        ST_HOLDOFF = 2'b10
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizers. Reset to 1 (button released) so that a key
    // held through reset is seen as a fresh falling edge afterwards.
    // ------------------------------------------------------------------
    logic [1:0] w_key_raw;
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;

    assign w_key_raw = {key1, key0};

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
        end else begin
            r_sync1 <= w_key_raw;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Debouncer per key. The counter advances on every cycle the
    // synchronized level disagrees with the accepted level; the accepted
    // level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
    // Any agreeing cycle restarts the count, so short glitches vanish.
    // ------------------------------------------------------------------
    logic [1:0]    r_stable;
    logic [DW-1:0] r_db_cnt [0:1];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_stable    <= 2'b11;
            r_db_cnt[0] <= '0;
            r_db_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Press detection: a 1->0 step of either stable level. Both keys
    // stepping together still give a single pulse; release edges are
    // ignored. The pulse is registered, costing one cycle.
    // ------------------------------------------------------------------
    logic [1:0] r_stable_d;
    logic [1:0] r_key_state;
    logic       r_press;
    logic       w_fall;

    assign w_fall = |(r_stable_d & ~r_stable);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_stable_d  <= 2'b11;
            r_key_state <= 2'b00;
            r_press     <= 1'b0;
        end else begin
            r_stable_d  <= r_stable;
            r_key_state <= ~r_stable;
            r_press     <= w_fall;
        end
    end

    // ------------------------------------------------------------------
    // Phase-step tick. The counter free-runs in every FSM state; tick is
    // registered so it rises in the cycle after the counter shows the
    // last value, giving the first tick TICK_PERIOD cycles after reset.
    // ------------------------------------------------------------------
    logic [TW-1:0] r_tick_cnt;
    logic          r_tick;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else begin
            if (r_tick_cnt == TICK_LAST) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
            r_tick <= (r_tick_cnt == TICK_LAST);
        end
    end

    // ------------------------------------------------------------------
    // Request FSM. The holdoff counter tracks ticks seen since entering
    // HOLDOFF; the edge that counts the last required tick returns to IDLE.
    // ------------------------------------------------------------------
    state_t        r_state;
    state_t        w_state_nxt;
    logic [HW-1:0] r_hold_cnt;
    logic [HW-1:0] w_hold_nxt;
    logic          w_count_inc;
    logic [7:0]    r_press_count;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_count_inc = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_hold_nxt = '0;
                if (r_press) begin
                    w_state_nxt = ST_PENDING;
                    w_count_inc = 1'b1;
                end
            end
            ST_PENDING: begin
                // Presses here are merged into the outstanding request.
                // An ack in the same cycle as a press wins; the press is lost.
                w_hold_nxt = '0;
                if (ped_ack) begin
                    w_state_nxt = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (HOLDOFF_TICKS == 0) begin
                    w_state_nxt = ST_IDLE;
                    w_hold_nxt  = '0;
                end else if (r_tick) begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_hold_nxt  = '0;
                    end else begin
                        w_hold_nxt = r_hold_cnt + 1'b1;
                    end
                end
            end
            default: begin
                // Unused encoding recovers to IDLE.
                w_state_nxt = ST_IDLE;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_press_count <= 8'd0;
        end else if (w_count_inc) begin
            r_press_count <= r_press_count + 8'd1;
        end
    end

    assign tick        = r_tick;
    assign ped_req     = (r_state == ST_PENDING);
    assign key_state   = r_key_state;
    assign press_count = r_press_count;

endmodule
